// File: rtl/inside_pkg.sv
// ============================================================================
// Module   : inside_pkg
// Purpose  : Width and bus-slice helpers for inside_range_check, all derived
//            from the base coordinate width N.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package inside_pkg;

  // Garbler-side coordinate widths
  function automatic int xd_w(input int n); return 4*n + 10; endfunction
  function automatic int yd_w(input int n); return 3*n + 7;  endfunction

  // Difference widths (one bit of headroom over the wider operand)
  function automatic int dx_w(input int n); return 4*n + 11; endfunction
  function automatic int dy_w(input int n); return 3*n + 8;  endfunction

  // Squared-distance width and radius width
  function automatic int d2_w(input int n); return 8*n + 23; endfunction
  function automatic int r_w(input int n);  return n + 1;    endfunction

  // Bus widths
  function automatic int g_w(input int n); return 7*n + 17; endfunction
  function automatic int e_w(input int n); return 3*n + 1;  endfunction

  // LSB offsets of the packed fields (yD and rA sit at bit 0)
  function automatic int xd_lsb(input int n); return 3*n + 7; endfunction
  function automatic int xa_lsb(input int n); return 2*n + 1; endfunction
  function automatic int ya_lsb(input int n); return n + 1;   endfunction

endpackage

`default_nettype wire

// File: rtl/signed_square.sv
// ============================================================================
// Module   : signed_square
// Purpose  : Combinational square of a signed W-bit value, returned as an
//            unsigned 2W-bit magnitude. Never overflows: |-2^(W-1)|^2 = 2^(2W-2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module signed_square #(
  parameter int W = 8
) (
  input  logic signed [W-1:0]   i_a,
  output logic        [2*W-1:0] o_sq
);

  logic signed [2*W-1:0] w_a_ext;
  logic signed [2*W-1:0] w_prod;

  // Sign-extend to the product width so the multiply is full precision
  always_comb begin
    w_a_ext = {{W{i_a[W-1]}}, i_a};
    w_prod  = w_a_ext * w_a_ext;
    o_sq    = w_prod;
  end

endmodule

`default_nettype wire

// File: rtl/inside_range_check.sv
// ============================================================================
// Module   : inside_range_check
// Purpose  : Two-stage pipelined test of whether point D lies inside or on
//            the circle centred at A with radius rA. Output o is registered,
//            latency 2 cycles, one new input set per cycle.
// Options  : INSIDE_STRICT_EN - when defined the test is strict (d2 < r2),
//            so points exactly on the circle count as outside.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inside_range_check
  import inside_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7*N+16:0]      g_input,
  input  logic [3*N:0]         e_input,
  output logic                 o
);

  localparam int XD_W = xd_w(N);
  localparam int YD_W = yd_w(N);
  localparam int DX_W = dx_w(N);
  localparam int DY_W = dy_w(N);
  localparam int D2_W = d2_w(N);
  localparam int R_W  = r_w(N);

  localparam int XD_LSB = xd_lsb(N);
  localparam int XA_LSB = xa_lsb(N);
  localparam int YA_LSB = ya_lsb(N);

  // Field extraction
  logic [XD_W-1:0] w_xd;
  logic [YD_W-1:0] w_yd;
  logic [N-1:0]    w_xa;
  logic [N-1:0]    w_ya;
  logic [R_W-1:0]  w_ra;

  assign w_xd = g_input[XD_LSB +: XD_W];
  assign w_yd = g_input[0 +: YD_W];
  assign w_xa = e_input[XA_LSB +: N];
  assign w_ya = e_input[YA_LSB +: N];
  assign w_ra = e_input[0 +: R_W];

  // Stage-1 differences: sign-extend every operand before subtracting
  logic [DX_W-1:0] w_dx;
  logic [DY_W-1:0] w_dy;

  assign w_dx = {{(DX_W-XD_W){w_xd[XD_W-1]}}, w_xd} - {{(DX_W-N){w_xa[N-1]}}, w_xa};
  assign w_dy = {{(DY_W-YD_W){w_yd[YD_W-1]}}, w_yd} - {{(DY_W-N){w_ya[N-1]}}, w_ya};

  logic [DX_W-1:0] r_dx;
  logic [DY_W-1:0] r_dy;
  logic [R_W-1:0]  r_r;

  // Stage 1 register: differences and radius
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dx <= '0;
      r_dy <= '0;
      r_r  <= '0;
    end else begin
      r_dx <= w_dx;
      r_dy <= w_dy;
      r_r  <= w_ra;
    end
  end

  // Stage-2 arithmetic
  logic [2*DX_W-1:0] w_dx_sq;
  logic [2*DY_W-1:0] w_dy_sq;
  logic [2*R_W-1:0]  w_r_wide;
  logic [2*R_W-1:0]  w_r2;
  logic [D2_W-1:0]   w_d2;
  logic [D2_W-1:0]   w_r2_ext;
  logic              w_inside;

  signed_square #(.W(DX_W)) u_sq_dx (
    .i_a  (r_dx),
    .o_sq (w_dx_sq)
  );

  signed_square #(.W(DY_W)) u_sq_dy (
    .i_a  (r_dy),
    .o_sq (w_dy_sq)
  );

  // Radius is unsigned, so zero-extend before squaring
  assign w_r_wide = {{R_W{1'b0}}, r_r};
  assign w_r2     = w_r_wide * w_r_wide;

  assign w_d2     = {{(D2_W-2*DX_W){1'b0}}, w_dx_sq} + {{(D2_W-2*DY_W){1'b0}}, w_dy_sq};
  assign w_r2_ext = {{(D2_W-2*R_W){1'b0}}, w_r2};

`ifdef INSIDE_STRICT_EN
  assign w_inside = (w_d2 <  w_r2_ext);
`else
  assign w_inside = (w_d2 <= w_r2_ext);
`endif

  // Stage 2 register: decision bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o <= 1'b0;
    end else begin
      o <= w_inside;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inside_range_check.sv
// ============================================================================
// Module   : tb_inside_range_check
// Purpose  : Self-checking bench for inside_range_check: directed vectors,
//            reset behaviour and randomized inputs against a wide-integer
//            geometric reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inside_range_check;

  localparam int N = 8;

  logic            clk;
  logic            rst;
  logic [7*N+16:0] g_input;
  logic [3*N:0]    e_input;
  logic            o;

  int n_checks;
  int n_pass;

  // Expected values in flight through the two-cycle pipeline
  logic e1, e2;
  bit   v1, v2;

  inside_range_check #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .g_input (g_input),
    .e_input (e_input),
    .o       (o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Geometric reference: squared Euclidean distance vs squared radius
  function automatic logic model(input longint xd, input longint yd,
                                 input longint xa, input longint ya,
                                 input longint ra);
    logic signed [127:0] dx, dy, d2, r2, rr;
    dx = xd - xa;
    dy = yd - ya;
    rr = ra;
    d2 = dx * dx + dy * dy;
    r2 = rr * rr;
`ifdef INSIDE_STRICT_EN
    return d2 < r2;
`else
    return d2 <= r2;
`endif
  endfunction

  // Pack fields and record the expected result; called just after an edge
  task automatic apply(input longint xd, input longint yd,
                       input longint xa, input longint ya, input longint ra);
    logic [4*N+9:0] xdb;
    logic [3*N+6:0] ydb;
    logic [N-1:0]   xab, yab;
    logic [N:0]     rab;
    xdb = xd[4*N+9:0];
    ydb = yd[3*N+6:0];
    xab = xa[N-1:0];
    yab = ya[N-1:0];
    rab = ra[N:0];
    g_input = {xdb, ydb};
    e_input = {xab, yab, rab};
    e1 = model(xd, yd, xa, ya, ra);
    v1 = 1'b1;
  endtask

  // Advance one cycle: check the result for inputs applied two edges ago
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    if (v2) check_bit(tag, o, e2);
    e2 = e1;
    v2 = v1;
    v1 = 1'b0;
  endtask

  longint xd, yd, xa, ya, ra;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    v1 = 0; v2 = 0; e1 = 0; e2 = 0;
    g_input = '0;
    e_input = '0;
    rst = 1'b1;
    #2;
    check_bit("reset_async", o, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_bit("reset_hold", o, 1'b0);
    rst = 1'b0;

    // Directed vectors on consecutive cycles, then the extreme corner
    apply(151, -276, -32, 108, 215);      step("vec_outside_a");
    apply(-231, 5, 109, -99, 183);        step("vec_outside_b");
    apply(-72, -102, -16, -111, 236);     step("vec_inside");
    apply(3, 4, 0, 0, 5);                 step("vec_on_circle");
    apply(-(64'sd1 <<< (4*N+9)), -(64'sd1 <<< (3*N+6)), 127, 127, 511);
    step("vec_extreme");
    apply(5, -7, 5, -7, 0);               step("r0_equal");
    apply(6, -7, 5, -7, 0);               step("r0_offset");
    apply(-128, -128, -128, -128, 0);     step("r0_neg_corner");
    apply(-128, 127, 127, -128, 511);     step("near_full");
    step("drain");
    step("drain");

    // Mid-operation asynchronous reset with a known inside result in flight
    apply(0, 0, 0, 0, 1);
    step("pre_reset");
    step("pre_reset");
    check_bit("pre_reset_one", o, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_bit("reset_midcycle", o, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_bit("reset_across_edge", o, 1'b0);
    end
    rst = 1'b0;
    v1 = 0; v2 = 0;
    g_input = '0;
    e_input = '0;
    step("post_reset");
    step("post_reset");
    check_bit("post_reset_origin", o, 1'b1);

    // Randomized: mixture of near-anchor points and full-range points
    for (int i = 0; i < 400; i++) begin
      xa = longint'($signed(8'($urandom)));
      ya = longint'($signed(8'($urandom)));
      ra = longint'($urandom_range(511));
      if ($urandom_range(3) != 0) begin
        xd = xa + longint'($urandom_range(1000)) - 500;
        yd = ya + longint'($urandom_range(1000)) - 500;
      end else begin
        xd = longint'($signed(42'({$urandom, $urandom})));
        yd = longint'($signed(31'($urandom)));
      end
      apply(xd, yd, xa, ya, ra);
      step("random");
    end
    step("drain");
    step("drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inside_range_check.md
Name: inside_range_check

Overview:
Range-decision block for triangle localization. It decides whether the garbler-side point D = (xD, yD) lies inside or on the circle centred at the evaluator-side anchor A = (xA, yA) with radius rA. The two parties' values arrive as packed buses g_input and e_input. The result is a single registered bit o that feeds the localization decision logic.

Parameters:
N, 8, base coordinate width; sets every bus and internal width.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
g_input  input  7N+17  garbler bus.
- [7N+16:3N+7] = xD, signed two's complement, 4N+10 bits.
- [3N+6:0] = yD, signed, 3N+7 bits.
e_input  input  3N+1  evaluator bus.
- [3N:2N+1] = xA, signed, N bits.
- [2N:N+1] = yA, signed, N bits.
- [N:0] = rA, unsigned, N+1 bits.
o  output  1  1 = D inside or on circle (A, rA); 0 = outside.

Behaviour:
- Reset: while rst is high, o = 0 and all pipeline registers = 0, asynchronously. Reset wins over a concurrent clock edge. Reset mid-operation discards in-flight results.
- Stage 1 (registered):
  - dx = xD − sext(xA), 4N+11 bits signed.
  - dy = yD − sext(yA), 3N+8 bits signed.
  - r = rA, zero-extended.
- Stage 2 (registered into o):
  - d2 = dx² + dy², unsigned, 8N+23 bits.
  - r2 = r², unsigned, 2N+2 bits, zero-extended to the d2 width.
  - o = (d2 <= r2).
- Latency: exactly 2 clk cycles from input change to o. Fully pipelined: a new input set is accepted every cycle. No handshake.
- Arithmetic:
  - All widths are sized so no overflow or truncation occurs for any input combination.
  - Sign extension is mandatory for xA, yA, xD and yD.
  - rA is never sign-extended.
- Boundaries:
  - d2 == r2 gives o = 1 (on-circle counts as inside).
  - rA = 0 gives o = 1 only when D == A.
  - Extreme negative xD/yD and extreme xA/yA must not overflow.
  - Output is deterministic for all inputs; no X propagation after reset.

Optional Feature:
Macro INSIDE_STRICT_EN.
- Defined: the comparison is strict, o = (d2 < r2), so on-circle points count as outside.
- Undefined (default): o = (d2 <= r2).
- Latency, widths and reset behaviour are identical in both builds.

Decomposition:
- Shared package inside_pkg holds the width constants as functions of N:
  - XD_W = 4N+10, YD_W = 3N+7
  - DX_W = 4N+11, DY_W = 3N+8
  - D2_W = 8N+23, R_W = N+1
  - bus slice offsets for g_input and e_input
- One sub-module is natural: signed_square. It takes a parameterised width W, a signed W-bit input, and produces an unsigned 2W-bit square. It is instantiated for dx and dy; r² uses an unsigned variant or zero-extended input.

Test Plan:
- Reset: assert rst asynchronously, mid-clock → o = 0 immediately. Hold across edges → o stays 0.
- Outside: xD=151, yD=−276, xA=−32, yA=108, rA=215 → d2 = 180945 > 46225 → o = 0 two cycles later.
- Outside: xD=−231, yD=5, xA=109, yA=−99, rA=183 → d2 = 126416 > 33489 → o = 0.
- Inside: xD=−72, yD=−102, xA=−16, yA=−111, rA=236 → d2 = 3217 < 55696 → o = 1.
- Boundary: xD=3, yD=4, xA=0, yA=0, rA=5 → d2 = 25 = r2 → o = 1 by default; o = 0 with INSIDE_STRICT_EN.
- Pipeline and extremes: apply the four vectors above on consecutive cycles → o sequence 0, 0, 1, 1 (1 under INSIDE_STRICT_EN for the last only if strict passes; 0 for it) starting at cycle 2. Then xD = −2^(4N+9), yD = −2^(3N+6), xA = 127, yA = 127, rA = 511 → o = 0 with no overflow.
